// File: rtl/uart_packet_tx.sv
// Framed packet transmitter: sync byte, payload bytes LSB first, 8-bit checksum,
// handed one byte at a time to a UART transmitter through its enable/busy handshake.
module uart_packet_tx #(
  parameter int unsigned WORD_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [8*WORD_BYTES-1:0] word_data,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [7:0]              tx_byte_data,
  output logic                    tx_byte_en,
  input  logic                    tx_busy,
  output logic                    pkt_done,
  output logic                    busy
);

  localparam int unsigned PAY_W = 8 * WORD_BYTES;
  localparam int unsigned IDX_W = $clog2(WORD_BYTES + 2);
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] PAY_END  = IDX_W'(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PAY_W-1:0]   payload_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         acc_q;
  logic               accept;
  logic               load_next;
  logic               last_byte;

  assign last_byte = (idx_q == CSUM_IDX);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (word_valid) state_d = S_ISSUE;
      S_ISSUE:     if (!tx_busy)   state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (tx_busy)    state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy)   state_d = last_byte ? S_DONE : S_ISSUE;
      S_DONE:                      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output and datapath-control decode
  always_comb begin
    word_ready = 1'b0;
    busy       = 1'b1;
    pkt_done   = 1'b0;
    tx_byte_en = 1'b0;
    accept     = 1'b0;
    load_next  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        word_ready = 1'b1;
        busy       = 1'b0;
        accept     = word_valid;
      end
      S_ISSUE:     tx_byte_en = !tx_busy;
      S_WAIT_ACK:  ;
      S_WAIT_DONE: load_next = !tx_busy && !last_byte;
      S_DONE:      pkt_done = 1'b1;
      default:     ;
    endcase
  end

  // Payload shifts out LSB byte first; checksum accumulates as each byte is loaded
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      payload_q    <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      tx_byte_data <= '0;
    end else if (accept) begin
      payload_q    <= word_data;
      idx_q        <= '0;
      acc_q        <= '0;
      tx_byte_data <= SYNC_BYTE;
    end else if (load_next) begin
      idx_q <= idx_q + IDX_W'(1);
      if (idx_q < PAY_END) begin
        tx_byte_data <= payload_q[7:0];
        acc_q        <= acc_q + payload_q[7:0];
        payload_q    <= payload_q >> 8;
      end else begin
        tx_byte_data <= acc_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: table of words with expected byte streams,
// plus hand sequences for occupied transmitter, back-to-back, stray valid and reset.
module tb_uart_packet_tx;

  localparam int unsigned WB       = 4;
  localparam int unsigned BUSY_CYC = 10;
  localparam int unsigned NVEC     = 8;

  typedef struct {
    logic [31:0]     word;
    logic [5:0][7:0] bytes;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  tx_byte_data;
  logic        tx_byte_en;
  logic        tx_busy;
  logic        pkt_done;
  logic        busy;
  logic        hold_busy;

  int unsigned cnt         = 0;
  int          en_pulses   = 0;
  int          done_pulses = 0;
  int          viol        = 0;
  logic        prev_en     = 1'b0;
  logic [7:0]  bytes_q[$];

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  uart_packet_tx #(.WORD_BYTES(WB), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .tx_byte_data (tx_byte_data),
    .tx_byte_en   (tx_byte_en),
    .tx_busy      (tx_busy),
    .pkt_done     (pkt_done),
    .busy         (busy)
  );

  // UART transmitter model: busy for BUSY_CYC cycles starting the cycle after an enable
  assign tx_busy = (cnt != 0) || hold_busy;

  always @(posedge clk) begin
    prev_en <= tx_byte_en;
    if (tx_byte_en) begin
      en_pulses <= en_pulses + 1;
      bytes_q.push_back(tx_byte_data);
      if (prev_en || tx_busy) viol <= viol + 1;
    end
    if (pkt_done) done_pulses <= done_pulses + 1;
    if (tx_byte_en && !tx_busy) cnt <= BUSY_CYC;
    else if (cnt != 0)          cnt <= cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name, input int base, input logic [5:0][7:0] exp);
    check({name, " len"}, 32'(bytes_q.size() >= base + 6), 32'd1);
    for (int j = 0; j < 6; j++) begin
      if (base + j < bytes_q.size())
        check($sformatf("%s byte%0d", name, j), 32'(bytes_q[base + j]), 32'(exp[j]));
    end
  endtask

  // Present a word at a negedge and hold valid until it is taken; returns in the cycle after accept
  task automatic send(input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    word_data  = w;
    word_valid = 1'b1;
    while (!word_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!word_ready) check("send timeout", 32'd0, 32'd1);
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!pkt_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!pkt_done) check("pkt_done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int en0;
    int held_en;
    int stray_ready;
    int t;

    vecs[0] = '{32'h04030201, 48'h0A_04_03_02_01_A5};
    vecs[1] = '{32'hFFFFFFFF, 48'hFC_FF_FF_FF_FF_A5};
    vecs[2] = '{32'h11223344, 48'hAA_11_22_33_44_A5};
    vecs[3] = '{32'hAABBCCDD, 48'h0E_AA_BB_CC_DD_A5};
    vecs[4] = '{32'h00000000, 48'h00_00_00_00_00_A5};
    vecs[5] = '{32'h80808080, 48'h00_80_80_80_80_A5};
    vecs[6] = '{32'h12345678, 48'h14_12_34_56_78_A5};
    vecs[7] = '{32'h0102FF01, 48'h03_01_02_FF_01_A5};

    resetn     = 1'b0;
    word_data  = '0;
    word_valid = 1'b0;
    hold_busy  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst word_ready", 32'(word_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tx_byte_en", 32'(tx_byte_en), 32'd0);
    check("rst pkt_done", 32'(pkt_done), 32'd0);
    check("rst tx_byte_data", 32'(tx_byte_data), 32'h00);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      bytes_q.delete();
      en0 = en_pulses;
      send(vecs[i].word);
      check($sformatf("vec%0d busy after accept", i), 32'(busy), 32'd1);
      check($sformatf("vec%0d ready after accept", i), 32'(word_ready), 32'd0);
      wait_done();
      check_stream($sformatf("vec%0d", i), 0, vecs[i].bytes);
      check($sformatf("vec%0d en count", i), 32'(en_pulses - en0), 32'd6);
      @(negedge clk);
      check($sformatf("vec%0d ready after done", i), 32'(word_ready), 32'd1);
    end

    // Transmitter occupied at accept: enable withheld until busy drops
    bytes_q.delete();
    hold_busy = 1'b1;
    send(32'h04030201);
    held_en = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_byte_en) held_en++;
      @(negedge clk);
    end
    check("occupied en while held", 32'(held_en), 32'd0);
    check("occupied state busy", 32'(busy), 32'd1);
    hold_busy = 1'b0;
    #1;
    check("occupied en on release", 32'(tx_byte_en), 32'd1);
    check("occupied first byte", 32'(tx_byte_data), 32'hA5);
    wait_done();
    check_stream("occupied", 0, 48'h0A_04_03_02_01_A5);
    @(negedge clk);

    // Back-to-back with valid held: second word taken the cycle after pkt_done
    bytes_q.delete();
    en0 = en_pulses;
    @(negedge clk);
    word_data  = 32'h11223344;
    word_valid = 1'b1;
    @(negedge clk);
    check("b2b first accepted", 32'(busy), 32'd1);
    word_data = 32'hAABBCCDD;
    wait_done();
    @(negedge clk);
    check("b2b idle after done", 32'(word_ready), 32'd1);
    @(negedge clk);
    check("b2b second accepted busy", 32'(busy), 32'd1);
    check("b2b second accepted ready", 32'(word_ready), 32'd0);
    word_valid = 1'b0;
    wait_done();
    check_stream("b2b pkt1", 0, 48'hAA_11_22_33_44_A5);
    check_stream("b2b pkt2", 6, 48'h0E_AA_BB_CC_DD_A5);
    check("b2b en count", 32'(en_pulses - en0), 32'd12);
    @(negedge clk);

    // Stray valid toggling mid-packet must not disturb the stream
    bytes_q.delete();
    send(32'h04030201);
    stray_ready = 0;
    t = 0;
    while (!pkt_done && t < 300) begin
      if (word_ready) stray_ready++;
      word_valid = ~word_valid;
      word_data  = $urandom;
      @(negedge clk);
      t++;
    end
    word_valid = 1'b0;
    check("stray reached done", 32'(pkt_done), 32'd1);
    check("stray ready mid-packet", 32'(stray_ready), 32'd0);
    check_stream("stray", 0, 48'h0A_04_03_02_01_A5);
    en0 = en_pulses;
    repeat (20) @(negedge clk);
    check("stray no extra packet", 32'(en_pulses - en0), 32'd0);

    // Reset while a payload byte is in flight
    bytes_q.delete();
    send(32'h04030201);
    t = 0;
    while (bytes_q.size() < 3 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("reset reached payload byte", 32'(bytes_q.size()), 32'd3);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst tx_byte_en", 32'(tx_byte_en), 32'd0);
    check("mid rst word_ready", 32'(word_ready), 32'd1);
    check("mid rst tx_byte_data", 32'(tx_byte_data), 32'h00);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    bytes_q.delete();
    en0 = en_pulses;
    send(32'h12345678);
    wait_done();
    check_stream("post reset", 0, 48'h14_12_34_56_78_A5);
    check("post reset en count", 32'(en_pulses - en0), 32'd6);

    repeat (5) @(negedge clk);
    check("total pkt_done pulses", 32'(done_pulses), 32'(NVEC + 5));
    check("enable rate violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
